// File: rtl/chocorol_pkg.sv
// Shared constants, instruction field layout and sequencer state encoding
// for the chocorol datapath and its instruction sequencer.
package chocorol_pkg;

    localparam int unsigned INSTR_W    = 20;
    localparam int unsigned PROG_DEPTH = 64;
    localparam int unsigned AW         = 6;
    localparam int unsigned LW         = AW + 1;

    typedef logic [INSTR_W-1:0] instr_t;

    localparam instr_t NOP = 20'h00000;

    // Instruction field positions as decoded by the datapath
    localparam int unsigned WE_A_BIT     = 18;
    localparam int unsigned WE_B_BIT     = 19;
    localparam int unsigned DE_LSB       = 0;
    localparam int unsigned DE_MSB       = 5;
    localparam int unsigned DL1_LSB      = 6;
    localparam int unsigned DL1_MSB      = 11;
    localparam int unsigned DL2_LSB      = 12;
    localparam int unsigned DL2_MSB      = 17;
    localparam int unsigned ALU_SEL_LSB  = 0;
    localparam int unsigned ALU_SEL_MSB  = 3;
    localparam int unsigned MEMB_DIR_LSB = 0;
    localparam int unsigned MEMB_DIR_MSB = 4;

    typedef enum logic [1:0] {
        INACTIVO = 2'd0,
        EJECUTA  = 2'd1,
        FIN      = 2'd2
    } estado_t;

endpackage

// File: rtl/secuenciador_instrucciones_if.sv
// Host/datapath-facing signal bundle of the instruction sequencer.
interface secuenciador_instrucciones_if;
    import chocorol_pkg::*;

    logic          carga_en;
    logic [AW-1:0] carga_dir;
    instr_t        carga_dato;
    logic          inicio;
    logic [LW-1:0] num_instr;
    logic          pausa;

    instr_t        Instruccion;
    logic          instr_valida;
    logic [AW-1:0] PC;
    logic          ocupado;
    logic          fin;

    modport master (
        output carga_en, carga_dir, carga_dato, inicio, num_instr, pausa,
        input  Instruccion, instr_valida, PC, ocupado, fin
    );

    modport slave (
        input  carga_en, carga_dir, carga_dato, inicio, num_instr, pausa,
        output Instruccion, instr_valida, PC, ocupado, fin
    );

endinterface

// File: rtl/secuenciador_instrucciones_memoria.sv
// Program store: one synchronous write port, asynchronous read, no reset on the array.
module memoria_programa
    import chocorol_pkg::*;
(
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_wdir,
    input  instr_t        i_wdato,
    input  logic [AW-1:0] i_rdir,
    output instr_t        o_rdato_c
);

    instr_t r_mem [PROG_DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_wdir] <= i_wdato;
        end
    end

    assign o_rdato_c = r_mem[i_rdir];

endmodule

// File: rtl/secuenciador_instrucciones.sv
// Issues a loaded program to the chocorol datapath one word per cycle,
// forcing NOP whenever no valid word is presented.
module secuenciador_instrucciones
    import chocorol_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    secuenciador_instrucciones_if.slave  bus
);

    estado_t       r_estado, w_estado_sig;
    logic [AW-1:0] r_pc, w_pc_sig;
    logic [LW-1:0] r_len, w_len_sig;
    instr_t        r_instr, w_instr_sig;
    logic          r_valida, w_valida_sig;
    logic          r_fin, w_fin_sig;
    logic          r_ocupado, w_ocupado_sig;

    logic          w_we;
    instr_t        w_rdato;
    logic          w_ultimo;

    // Loads are only accepted while idle so a running program is never altered
    assign w_we = bus.carga_en && (r_estado == INACTIVO);

    memoria_programa u_memoria (
        .clk       (clk),
        .i_we      (w_we),
        .i_wdir    (bus.carga_dir),
        .i_wdato   (bus.carga_dato),
        .i_rdir    (r_pc),
        .o_rdato_c (w_rdato)
    );

    assign w_ultimo = ({1'b0, r_pc} == (r_len - LW'(1)));

    // Next-state and next-output decode
    always_comb begin
        w_estado_sig  = r_estado;
        w_pc_sig      = r_pc;
        w_len_sig     = r_len;
        w_instr_sig   = NOP;
        w_valida_sig  = 1'b0;
        w_fin_sig     = 1'b0;
        w_ocupado_sig = 1'b0;

        unique case (r_estado)
            INACTIVO: begin
                if (bus.inicio && (bus.num_instr != '0)) begin
                    w_estado_sig  = EJECUTA;
                    w_pc_sig      = '0;
                    w_len_sig     = (bus.num_instr > LW'(PROG_DEPTH)) ?
                                    LW'(PROG_DEPTH) : bus.num_instr;
                    w_ocupado_sig = 1'b1;
                end
            end
            EJECUTA: begin
                w_ocupado_sig = 1'b1;
                if (!bus.pausa) begin
                    w_instr_sig  = w_rdato;
                    w_valida_sig = 1'b1;
                    // The last word leaves PC in place so it never wraps inside a run
                    if (w_ultimo) begin
                        w_estado_sig = FIN;
                    end else begin
                        w_pc_sig = r_pc + AW'(1);
                    end
                end
            end
            FIN: begin
                w_fin_sig     = 1'b1;
                w_ocupado_sig = 1'b1;
                w_pc_sig      = '0;
                w_estado_sig  = INACTIVO;
            end
            default: begin
                w_estado_sig = INACTIVO;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_estado  <= INACTIVO;
            r_pc      <= '0;
            r_len     <= '0;
            r_instr   <= NOP;
            r_valida  <= 1'b0;
            r_fin     <= 1'b0;
            r_ocupado <= 1'b0;
        end else begin
            r_estado  <= w_estado_sig;
            r_pc      <= w_pc_sig;
            r_len     <= w_len_sig;
            r_instr   <= w_instr_sig;
            r_valida  <= w_valida_sig;
            r_fin     <= w_fin_sig;
            r_ocupado <= w_ocupado_sig;
        end
    end

    assign bus.Instruccion  = r_instr;
    assign bus.instr_valida = r_valida;
    assign bus.PC           = r_pc;
    assign bus.ocupado      = r_ocupado;
    assign bus.fin          = r_fin;

endmodule

// File: tb/tb_secuenciador_instrucciones.sv
// Randomized self-checking bench for secuenciador_instrucciones against a
// program-order issue model.
`timescale 1ns/1ps
module tb_secuenciador_instrucciones;
    import chocorol_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    secuenciador_instrucciones_if bif ();

    secuenciador_instrucciones dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    int total = 0;
    int bad   = 0;

    instr_t prog [PROG_DEPTH];

    logic   ob_v [$];
    instr_t ob_i [$];
    logic   ob_f [$];
    int     ob_pc [$];
    logic   pz_q [$];
    int     pc_start;

    logic   e_v [$];
    instr_t e_i [$];
    logic   e_f [$];
    int     e_idx [$];

    task automatic load_word(input int dir, input instr_t dato);
        bif.carga_en   = 1'b1;
        bif.carga_dir  = AW'(dir);
        bif.carga_dato = dato;
        @(negedge clk);
        bif.carga_en   = 1'b0;
        prog[dir] = dato;
    endtask

    // Starts a run and records every cycle until fin or the cycle budget expires
    task automatic collect(input int n, input int pmode, input logic [63:0] pmask,
                           input bit hold_inicio, input bit poke, input int max_cyc);
        ob_v.delete(); ob_i.delete(); ob_f.delete(); ob_pc.delete(); pz_q.delete();
        bif.inicio    = 1'b1;
        bif.num_instr = LW'(n);
        @(negedge clk);
        if (!hold_inicio) bif.inicio = 1'b0;
        bif.carga_en = 1'b0;
        pc_start = int'(bif.PC);
        for (int c = 0; c < max_cyc; c++) begin
            logic p;
            if (pmode == 1)                p = ($urandom_range(0, 3) == 0);
            else if (pmode == 2 && c < 64) p = pmask[c];
            else                           p = 1'b0;
            bif.pausa = p;
            if (poke && c == 1) begin
                bif.carga_en   = 1'b1;
                bif.carga_dir  = AW'(1);
                bif.carga_dato = 20'hFFFFF;
            end else begin
                bif.carga_en = 1'b0;
            end
            @(negedge clk);
            pz_q.push_back(p);
            ob_v.push_back(bif.instr_valida);
            ob_i.push_back(bif.Instruccion);
            ob_f.push_back(bif.fin);
            ob_pc.push_back(int'(bif.PC));
            if (bif.fin) break;
        end
        bif.pausa    = 1'b0;
        bif.inicio   = 1'b0;
        bif.carga_en = 1'b0;
    endtask

    // Reference: words leave in program order on every unstalled cycle, fin follows the last
    function automatic void build_exp(input int n);
        int len;
        int idx;
        bit done;
        len  = (n > PROG_DEPTH) ? PROG_DEPTH : n;
        idx  = 0;
        done = 1'b0;
        e_v.delete(); e_i.delete(); e_f.delete(); e_idx.delete();
        foreach (pz_q[c]) begin
            if (idx < len) begin
                if (pz_q[c]) begin
                    e_v.push_back(1'b0); e_i.push_back(NOP); e_f.push_back(1'b0); e_idx.push_back(-1);
                end else begin
                    e_v.push_back(1'b1); e_i.push_back(prog[idx]); e_f.push_back(1'b0); e_idx.push_back(idx);
                    idx++;
                end
            end else begin
                e_v.push_back(1'b0); e_i.push_back(NOP); e_f.push_back(1'b1); e_idx.push_back(-1);
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            e_v.push_back(1'b0); e_i.push_back(NOP); e_f.push_back(1'b1); e_idx.push_back(-1);
        end
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        bif.carga_en = 1'b0; bif.carga_dir = '0; bif.carga_dato = '0;
        bif.inicio = 1'b0; bif.num_instr = '0; bif.pausa = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (bif.Instruccion !== NOP || bif.instr_valida !== 1'b0) begin
            bad++; $display("FAIL reset_instr got=%h/%b exp=00000/0", bif.Instruccion, bif.instr_valida);
        end
        total++;
        if (bif.PC !== '0 || bif.ocupado !== 1'b0 || bif.fin !== 1'b0) begin
            bad++; $display("FAIL reset_ctrl got pc=%0d ocup=%b fin=%b exp 0/0/0", bif.PC, bif.ocupado, bif.fin);
        end
    endtask

    task automatic test_basic();
        load_word(0, 20'h40001); load_word(1, 20'h00042);
        load_word(2, 20'h80083); load_word(3, 20'h000C4);
        collect(4, 0, 64'h0, 1'b0, 1'b0, 20);
        build_exp(4);
        total++;
        if (pc_start !== 0) begin bad++; $display("FAIL basic_pc_start got=%0d exp=0", pc_start); end
        total++;
        if (ob_v.size() != e_v.size()) begin
            bad++; $display("FAIL basic_len got=%0d exp=%0d", ob_v.size(), e_v.size());
        end
        foreach (e_v[c]) if (c < ob_v.size()) begin
            total++;
            if (ob_v[c] !== e_v[c] || ob_i[c] !== e_i[c] || ob_f[c] !== e_f[c]) begin
                bad++; $display("FAIL basic_cyc%0d got v=%b i=%h f=%b exp v=%b i=%h f=%b",
                                c, ob_v[c], ob_i[c], ob_f[c], e_v[c], e_i[c], e_f[c]);
            end
            if (e_idx[c] >= 0 && e_idx[c] < 3) begin
                total++;
                if (ob_pc[c] !== e_idx[c] + 1) begin
                    bad++; $display("FAIL basic_pc%0d got=%0d exp=%0d", c, ob_pc[c], e_idx[c] + 1);
                end
            end
        end
        total++;
        if (ob_pc[ob_pc.size()-1] !== 0) begin
            bad++; $display("FAIL basic_fin_pc got=%0d exp=0", ob_pc[ob_pc.size()-1]);
        end
        @(negedge clk);
        total++;
        if (bif.ocupado !== 1'b0 || bif.fin !== 1'b0) begin
            bad++; $display("FAIL basic_after got ocup=%b fin=%b exp 0/0", bif.ocupado, bif.fin);
        end
    endtask

    task automatic test_pause();
        int lows;
        collect(4, 2, 64'hC, 1'b0, 1'b0, 20);
        build_exp(4);
        total++;
        if (ob_v.size() != e_v.size()) begin
            bad++; $display("FAIL pause_len got=%0d exp=%0d", ob_v.size(), e_v.size());
        end
        lows = 0;
        foreach (e_v[c]) if (c < ob_v.size()) begin
            if (ob_v[c] === 1'b0 && ob_f[c] === 1'b0) lows++;
            total++;
            if (ob_v[c] !== e_v[c] || ob_i[c] !== e_i[c] || ob_f[c] !== e_f[c]) begin
                bad++; $display("FAIL pause_cyc%0d got v=%b i=%h f=%b exp v=%b i=%h f=%b",
                                c, ob_v[c], ob_i[c], ob_f[c], e_v[c], e_i[c], e_f[c]);
            end
        end
        total++;
        if (lows !== 2) begin bad++; $display("FAIL pause_gaps got=%0d exp=2", lows); end
    endtask

    task automatic test_zero_len();
        int errs;
        errs = 0;
        bif.inicio = 1'b1; bif.num_instr = '0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bif.ocupado !== 1'b0 || bif.fin !== 1'b0 || bif.instr_valida !== 1'b0) errs++;
        end
        bif.inicio = 1'b0;
        total++;
        if (errs != 0) begin bad++; $display("FAIL zero_len got=%0d active cycles exp=0", errs); end
    endtask

    task automatic test_full_len();
        int nv;
        for (int a = 0; a < PROG_DEPTH; a++) load_word(a, instr_t'($urandom));
        collect(100, 0, 64'h0, 1'b0, 1'b0, 200);
        build_exp(100);
        total++;
        if (ob_v.size() != e_v.size()) begin
            bad++; $display("FAIL full_len got=%0d exp=%0d", ob_v.size(), e_v.size());
        end
        nv = 0;
        foreach (e_v[c]) if (c < ob_v.size()) begin
            if (ob_v[c] === 1'b1) nv++;
            total++;
            if (ob_v[c] !== e_v[c] || ob_i[c] !== e_i[c] || ob_f[c] !== e_f[c]) begin
                bad++; $display("FAIL full_cyc%0d got v=%b i=%h f=%b exp v=%b i=%h f=%b",
                                c, ob_v[c], ob_i[c], ob_f[c], e_v[c], e_i[c], e_f[c]);
            end
            if (e_idx[c] >= 0 && e_idx[c] < PROG_DEPTH - 1) begin
                total++;
                if (ob_pc[c] !== e_idx[c] + 1) begin
                    bad++; $display("FAIL full_pc%0d got=%0d exp=%0d", c, ob_pc[c], e_idx[c] + 1);
                end
            end
        end
        total++;
        if (nv !== 64) begin bad++; $display("FAIL full_count got=%0d exp=64", nv); end
    endtask

    task automatic test_load_ignored();
        for (int a = 0; a < 4; a++) load_word(a, instr_t'($urandom));
        collect(4, 0, 64'h0, 1'b0, 1'b1, 20);
        collect(4, 0, 64'h0, 1'b0, 1'b0, 20);
        build_exp(4);
        total++;
        if (ob_v.size() != e_v.size()) begin
            bad++; $display("FAIL ignload_len got=%0d exp=%0d", ob_v.size(), e_v.size());
        end
        foreach (e_v[c]) if (c < ob_v.size()) begin
            total++;
            if (ob_v[c] !== e_v[c] || ob_i[c] !== e_i[c] || ob_f[c] !== e_f[c]) begin
                bad++; $display("FAIL ignload_cyc%0d got v=%b i=%h f=%b exp v=%b i=%h f=%b",
                                c, ob_v[c], ob_i[c], ob_f[c], e_v[c], e_i[c], e_f[c]);
            end
        end
    endtask

    task automatic test_reset_midrun();
        bif.inicio = 1'b1; bif.num_instr = LW'(4);
        @(negedge clk);
        bif.inicio = 1'b0;
        for (int c = 0; c < 10 && bif.PC !== AW'(2); c++) @(negedge clk);
        total++;
        if (bif.PC !== AW'(2)) begin bad++; $display("FAIL rst_reach_pc2 got=%0d exp=2", bif.PC); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if (bif.Instruccion !== NOP || bif.instr_valida !== 1'b0 || bif.PC !== '0 ||
            bif.ocupado !== 1'b0 || bif.fin !== 1'b0) begin
            bad++; $display("FAIL rst_mid got i=%h v=%b pc=%0d o=%b f=%b exp all 0",
                            bif.Instruccion, bif.instr_valida, bif.PC, bif.ocupado, bif.fin);
        end
        @(negedge clk);
        total++;
        if (bif.ocupado !== 1'b0 || bif.instr_valida !== 1'b0) begin
            bad++; $display("FAIL rst_idle got o=%b v=%b exp 0/0", bif.ocupado, bif.instr_valida);
        end
        collect(4, 0, 64'h0, 1'b0, 1'b0, 20);
        build_exp(4);
        total++;
        if (ob_v.size() != e_v.size()) begin
            bad++; $display("FAIL rst_replay_len got=%0d exp=%0d", ob_v.size(), e_v.size());
        end
        foreach (e_v[c]) if (c < ob_v.size()) begin
            total++;
            if (ob_v[c] !== e_v[c] || ob_i[c] !== e_i[c] || ob_f[c] !== e_f[c]) begin
                bad++; $display("FAIL rst_replay_cyc%0d got v=%b i=%h f=%b exp v=%b i=%h f=%b",
                                c, ob_v[c], ob_i[c], ob_f[c], e_v[c], e_i[c], e_f[c]);
            end
        end
    endtask

    task automatic test_inicio_held();
        int errs;
        collect(5, 0, 64'h0, 1'b1, 1'b0, 30);
        build_exp(5);
        total++;
        if (ob_v.size() != e_v.size()) begin
            bad++; $display("FAIL held_len got=%0d exp=%0d", ob_v.size(), e_v.size());
        end
        foreach (e_v[c]) if (c < ob_v.size()) begin
            total++;
            if (ob_v[c] !== e_v[c] || ob_i[c] !== e_i[c] || ob_f[c] !== e_f[c]) begin
                bad++; $display("FAIL held_cyc%0d got v=%b i=%h f=%b exp v=%b i=%h f=%b",
                                c, ob_v[c], ob_i[c], ob_f[c], e_v[c], e_i[c], e_f[c]);
            end
        end
        errs = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bif.instr_valida !== 1'b0 || bif.ocupado !== 1'b0 || bif.fin !== 1'b0) errs++;
        end
        total++;
        if (errs != 0) begin bad++; $display("FAIL held_rerun got=%0d busy cycles exp=0", errs); end
    endtask

    task automatic test_load_and_start();
        instr_t w;
        w = instr_t'($urandom);
        bif.carga_en = 1'b1; bif.carga_dir = '0; bif.carga_dato = w;
        prog[0] = w;
        collect(3, 0, 64'h0, 1'b0, 1'b0, 20);
        build_exp(3);
        total++;
        if (ob_v.size() != e_v.size()) begin
            bad++; $display("FAIL loadstart_len got=%0d exp=%0d", ob_v.size(), e_v.size());
        end
        foreach (e_v[c]) if (c < ob_v.size()) begin
            total++;
            if (ob_v[c] !== e_v[c] || ob_i[c] !== e_i[c] || ob_f[c] !== e_f[c]) begin
                bad++; $display("FAIL loadstart_cyc%0d got v=%b i=%h f=%b exp v=%b i=%h f=%b",
                                c, ob_v[c], ob_i[c], ob_f[c], e_v[c], e_i[c], e_f[c]);
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            int n;
            n = $urandom_range(1, 70);
            for (int a = 0; a < PROG_DEPTH; a++) load_word(a, instr_t'($urandom));
            collect(n, 1, 64'h0, 1'b0, 1'b0, 300);
            build_exp(n);
            total++;
            if (ob_v.size() != e_v.size()) begin
                bad++; $display("FAIL rand%0d_len got=%0d exp=%0d", it, ob_v.size(), e_v.size());
            end
            foreach (e_v[c]) if (c < ob_v.size()) begin
                total++;
                if (ob_v[c] !== e_v[c] || ob_i[c] !== e_i[c] || ob_f[c] !== e_f[c]) begin
                    bad++; $display("FAIL rand%0d_cyc%0d got v=%b i=%h f=%b exp v=%b i=%h f=%b",
                                    it, c, ob_v[c], ob_i[c], ob_f[c], e_v[c], e_i[c], e_f[c]);
                end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_pause();
        test_zero_len();
        test_load_ignored();
        test_reset_midrun();
        test_inicio_held();
        test_load_and_start();
        test_full_len();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/secuenciador_instrucciones.md
# secuenciador_instrucciones

Instruction sequencer that sits directly upstream of the `chocorol` datapath and drives its 20-bit `Instruccion` input. A host first loads a program into an internal 64×20 program memory. On a start pulse, the sequencer issues that program one instruction per cycle, honouring a downstream stall. When the datapath is not being fed a valid instruction, its input is forced to the all-zero NOP, which keeps both write enables (bits 18 and 19) low, because the datapath has no valid qualifier of its own.

## Interface
- `PROG_DEPTH`, 64: program memory depth in instructions.
- `AW`, 6: program counter and address width; equals log2(`PROG_DEPTH`).
- `INSTR_W`, 20: instruction width; fixed to the datapath's instruction format.

- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `carga_en`  in  1  program-load write strobe; honoured only in state INACTIVO.
- `carga_dir`  in  AW  program-load address.
- `carga_dato`  in  INSTR_W  program-load data.
- `inicio`  in  1  start request; sampled in INACTIVO only.
- `num_instr`  in  AW+1  program length; captured when `inicio` is accepted.
- `pausa`  in  1  downstream stall.
- `Instruccion`  out  INSTR_W  registered instruction to the datapath; 0 whenever `instr_valida`=0.
- `instr_valida`  out  1  `Instruccion` is a real program word this cycle.
- `PC`  out  AW  address of the next instruction to issue.
- `ocupado`  out  1  high in EJECUTA and FIN.
- `fin`  out  1  one-cycle pulse after the last instruction has been issued.

## Operation
- States:
  - INACTIVO (reset state), EJECUTA, FIN.
  - Encoding lives in the package.
- INACTIVO:
  - `carga_en`=1 writes `carga_dato` to `mem[carga_dir]`.
  - `inicio`=1 with `num_instr`≠0 → EJECUTA. `PC`←0 and `len`←min(`num_instr`, PROG_DEPTH).
  - `inicio` with `num_instr`=0 is ignored; the block stays INACTIVO.
  - If `inicio` and `carga_en` arrive together, the write completes first, then the start is taken.
- EJECUTA, `pausa`=0:
  - `Instruccion`←`mem[PC]`, `instr_valida`←1, `PC`←`PC`+1.
  - If `PC`=`len`-1, next state is FIN.
- EJECUTA, `pausa`=1:
  - `PC` holds, `instr_valida`←0, `Instruccion`←0.
  - The next unpaused cycle reissues from the held `PC`; no instruction is lost or duplicated.
- FIN:
  - `fin`=1, `instr_valida`=0, `Instruccion`=0, `PC`←0.
  - Next state is INACTIVO unconditionally; `pausa` is ignored.
- Ignored inputs:
  - `carga_en` and `inicio` are ignored in EJECUTA and FIN.
- `PC` arithmetic:
  - Arithmetic is modulo 2^AW.
  - With `len`=64, `PC` reaches 63 and then FIN resets it to 0; `PC` never wraps inside a run.
- Reset:
  - `rst`=1 in any state, including mid-run, forces INACTIVO.
  - All outputs go to 0: `Instruccion`, `instr_valida`, `PC`, `ocupado`, `fin`.
  - Program memory contents are NOT cleared; a new `inicio` replays the same program.

## Timing
- `inicio` sampled at edge k → first instruction (`mem[0]`) visible with `instr_valida`=1 after edge k+1.
- Latency from start to first instruction: 1 cycle.
- Unpaused run of length L:
  - `instr_valida` is high for exactly L consecutive cycles.
  - `fin` is high in the following cycle.
  - `ocupado` rises after edge k and falls after the `fin` cycle.
- `pausa` asserted during cycle c → `instr_valida`=0 in cycle c+1. Registered response, one cycle of lag.
- A load write at edge j is readable by a run started at edge j or later.
- Throughput: one instruction per cycle when unpaused.

## Structure
- Package `chocorol_pkg` holds:
  - `INSTR_W`=20 and `NOP`=20'h00000.
  - Field constants: `WE_A_BIT`=18, `WE_B_BIT`=19, DE [5:0], DL1 [11:6], DL2 [17:12], ALU_SEL [3:0], MEMB_DIR [4:0].
  - State enum `estado_t` {INACTIVO, EJECUTA, FIN}.
- Sub-module `memoria_programa`:
  - PROG_DEPTH×INSTR_W array, one write port, combinational read.
  - No reset on the array.
- The sequencer top holds the FSM, `PC`, `len` and the output register.

## Test plan
- Load `mem[0..3]` = 20'h40001, 20'h00042, 20'h80083, 20'h000C4; `inicio` with `num_instr`=4 → `Instruccion` shows those four values on 4 consecutive cycles with `instr_valida`=1, then `fin`=1 for one cycle, `PC`=0, `ocupado`=0.
- Same program, `pausa`=1 in the cycle after word 1 issues, held 2 cycles → `instr_valida` low 2 cycles, `Instruccion`=0 in those cycles, then words 2 and 3 issue once each.
- `num_instr`=0 with `inicio` → stays INACTIVO, `ocupado`=0, no `fin`; `num_instr`=100 → exactly 64 issued, `PC` sequence 0..63, then `fin`.
- `carga_en` to address 1 with 20'hFFFFF during a run → ignored; a rerun still issues the original `mem[1]`.
- `rst` pulsed when `PC`=2 in a 4-word run → next cycle all outputs 0 and state INACTIVO; a new `inicio` replays from `mem[0]` with the original contents.
- `inicio` held high through EJECUTA and FIN → exactly one run; a second run starts only on the next cycle spent in INACTIVO.
